div_frag_sequencer: RTL
=======================

# div_frag_sequencer

Issue/collect stage wrapped around the 21-bit fragment divider in the Render pipeline. Accepts per-fragment divide requests with a tag over a valid/ready handshake and issues them to the divider with a one-cycle `open` pulse. Re-attaches each returning quotient to its tag in issue order and buffers results, so the non-backpressurable divider output never overflows. Flags divide-by-zero with a saturated quotient.

## Interface
- `DEPTH`, 8: maximum outstanding requests (in divider plus result buffer); power of 2, ≥2
- `TAG_W`, 20: tag width (packed fragment x/y)
- `clk` input 1: sole clock, rising edge
- `rst_n` input 1: asynchronous active-low reset
- `in_valid` input 1: request valid
- `in_ready` output 1: request accepted when `in_valid & in_ready`
- `in_tag` input TAG_W: fragment tag
- `in_dividend` input 21: dividend
- `in_divisor` input 21: divisor
- `div_open` output 1: divider input valid, one-cycle pulse per request
- `div_dividend` output 21: registered dividend to divider
- `div_divisor` output 21: registered divisor to divider
- `div_finish` input 1: divider result valid (no backpressure)
- `div_quotient` input 21: divider quotient
- `out_valid` output 1: result valid
- `out_ready` input 1: result consumed when `out_valid & out_ready`
- `out_tag` output TAG_W: tag of the result
- `out_quotient` output 21: quotient, or 21'h1FFFFF on divide-by-zero
- `out_div0` output 1: request had divisor == 0
- `busy` output 1: `cnt != 0`
- `err` output 1: sticky protocol error

## Operation
- Credit counter `cnt` (0..DEPTH):
  - +1 on accept, −1 on output pop; both in the same cycle leaves it unchanged.
  - `in_ready = (cnt < DEPTH)`.
- Accept:
  - Registers `in_dividend`/`in_divisor` onto `div_*`; `div_open` is high exactly the next cycle.
  - Pushes `{in_tag, in_divisor==0}` into the tag FIFO (depth DEPTH).
  - `div_*` data holds its value until the next accept.
- `div_finish` sampled high:
  - Pops the tag FIFO head.
  - Writes `{tag, q, div0}` into the result FIFO (depth DEPTH), where `q = div0 ? 21'h1FFFFF : div_quotient`.
  - Zero-divisor requests still go through the divider so ordering is preserved; the divider's returned value for them is discarded.
- Result FIFO is show-ahead:
  - `out_*` reflect the head entry; `out_valid` = not empty.
  - `out_*` hold stable while `out_valid & !out_ready`.
- Results leave in acceptance order.
- Overflow impossible by construction: tag FIFO entries + result FIFO entries ≤ `cnt` ≤ DEPTH.
- `div_finish` with an empty tag FIFO: result discarded, `err` set; `err` cleared only by reset.
- Pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit.

## Timing
- Reset values (async, while `rst_n` low):
  - `cnt` = 0, both FIFOs empty.
  - `div_open` = 0, `div_dividend`/`div_divisor` = 0.
  - `out_valid` = 0, `out_tag`/`out_quotient` = 0, `out_div0` = 0.
  - `busy` = 0, `err` = 0, `in_ready` = 0.
- `in_ready` = 1 from the first cycle after reset release.
- Accept at edge T:
  - `div_open` high in cycle T..T+1.
  - For divider latency L, `div_finish` is sampled at edge T+1+L.
  - `out_valid` is high from cycle T+1+L..T+2+L if the result FIFO was empty, giving L+2 cycles end to end.
- Full throughput: one accept and one pop per cycle sustained; `in_ready` drops in the cycle after `cnt` reaches DEPTH.
- Pop and accept in the same cycle at `cnt == DEPTH`: the accept is not allowed, because `in_ready` is derived from the registered `cnt` only.
- `div_finish` and output pop in the same cycle: both take effect; a write into an empty FIFO does not bypass to `out_*` in that cycle.
- Reset mid-operation:
  - All state is discarded; `div_finish` is ignored while `rst_n` is low.
  - The divider IP has no reset, so system reset must hold `rst_n` low ≥ L+2 cycles to drain in-flight results; otherwise late finishes set `err`.

## Test plan
- **Single request:** bench divider model has L = 25. Accept dividend 100, divisor 7, tag 0x00ABC → `div_open` one cycle after accept; `out_valid` 27 cycles after accept with quotient 14, tag 0x00ABC, `out_div0` 0.
- **Divide-by-zero:** dividend 55, divisor 0, tag 5 → `out_quotient` 21'h1FFFFF, `out_div0` 1; an adjacent 9/3 request still returns 3 in order.
- **Backpressure fill:** hold `out_ready` = 0 and offer 12 back-to-back requests with DEPTH = 8 → exactly 8 accepted; `in_ready` low from the cycle after the 8th accept; `err` stays 0. Then release `out_ready` → 8 results in order, one per cycle, and `in_ready` returns.
- **Streaming:** 100 random requests with `out_ready` randomly toggled → every quotient equals dividend/divisor in issue order; `cnt` never exceeds 8; simultaneous accept and pop observed with `cnt` unchanged.
- **Reset mid-flight:** 4 requests in flight; assert `rst_n` low for 30 cycles → all outputs at reset values; after release, a fresh request of 21 divided by 4 returns 5 and `err` stays 0.
- **Protocol error:** inject `div_finish` with no outstanding request → `err` 1 and stays 1; `out_valid` stays 0.

Source files
------------

// File: rtl/div_frag_sequencer.sv
// Purpose: issues tagged divide requests to the fragment divider and re-pairs each quotient with its tag, in order.
// Latency: L+2 cycles from accept to out_valid for a divider of latency L when the result buffer is empty.
// Backpressure: in_ready while fewer than DEPTH requests are outstanding; out_* hold while out_valid & !out_ready; divider output never stalls.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready, in_tag,
//   in_dividend, in_divisor         request handshake and payload
//   div_open, div_dividend,
//   div_divisor                     one-cycle issue pulse and registered operands to the divider
//   div_finish, div_quotient        divider result (no backpressure)
//   out_valid/out_ready, out_tag,
//   out_quotient, out_div0          in-order result handshake and payload
//   busy, err                       requests outstanding, sticky protocol error

// Purpose: generic show-ahead FIFO, power-of-2 depth.
// Latency: a write is visible on rd_* the cycle after it is written.
// Backpressure: writes when full and reads when empty are ignored.
module div_frag_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld_i,
    input  logic [W-1:0] wr_dat_i,
    input  logic         rd_rdy_i,
    output logic         rd_vld_o,
    output logic [W-1:0] rd_dat_o
);
    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer separates full from empty.
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         empty, full, wr_en, rd_en;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_en    = wr_vld_i & ~full;
    assign rd_en    = rd_rdy_i & ~empty;
    assign rd_vld_o = ~empty;
    assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: it is only observed through rd_vld_o.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end
endmodule

module div_frag_sequencer #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [20:0]      in_dividend,
    input  logic [20:0]      in_divisor,
    output logic             div_open,
    output logic [20:0]      div_dividend,
    output logic [20:0]      div_divisor,
    input  logic             div_finish,
    input  logic [20:0]      div_quotient,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [20:0]      out_quotient,
    output logic             out_div0,
    output logic             busy,
    output logic             err
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam int            TW      = TAG_W + 1;   // {tag, div0}
    localparam int            RW      = TAG_W + 22;  // {tag, quotient, div0}
    localparam logic [20:0]   Q_SAT   = 21'h1FFFFF;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_en_q;
    logic          div_open_q;
    logic [20:0]   dvd_q, dvd_d, dvs_q, dvs_d;
    logic          err_q, err_d;
    logic          accept, pop;
    logic          tag_vld;
    logic [TW-1:0] tag_dat;
    logic          res_wr;
    logic [RW-1:0] res_wr_dat;
    logic          res_vld;
    logic [RW-1:0] res_dat;
    logic [20:0]   q_fix;

    // ready_en_q keeps in_ready low during reset even though cnt is 0 then.
    assign in_ready = ready_en_q & (cnt_q < DEPTH_C);
    assign accept   = in_valid & in_ready;
    assign pop      = res_vld & out_ready;

    // Credits cover both the divider pipeline and the result buffer, so
    // neither FIFO can overflow and the divider never needs to stall.
    assign cnt_d = cnt_q + CW'(accept) - CW'(pop);
    assign dvd_d = accept ? in_dividend : dvd_q;
    assign dvs_d = accept ? in_divisor  : dvs_q;

    // A finish with no tag waiting is unmatched: drop it and flag.
    assign res_wr     = div_finish & tag_vld;
    assign q_fix      = tag_dat[0] ? Q_SAT : div_quotient;
    assign res_wr_dat = {tag_dat[TW-1:1], q_fix, tag_dat[0]};
    assign err_d      = err_q | (div_finish & ~tag_vld);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
            div_open_q <= 1'b0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
            div_open_q <= accept;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            err_q      <= err_d;
        end
    end

    div_frag_fifo #(.W(TW), .DEPTH(DEPTH)) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_vld_i (accept),
        .wr_dat_i ({in_tag, (in_divisor == 21'd0)}),
        .rd_rdy_i (div_finish),
        .rd_vld_o (tag_vld),
        .rd_dat_o (tag_dat)
    );

    div_frag_fifo #(.W(RW), .DEPTH(DEPTH)) u_res_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_vld_i (res_wr),
        .wr_dat_i (res_wr_dat),
        .rd_rdy_i (out_ready),
        .rd_vld_o (res_vld),
        .rd_dat_o (res_dat)
    );

    assign div_open     = div_open_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;

    // Payload is masked when empty so out_* read zero out of reset.
    assign out_valid    = res_vld;
    assign out_tag      = res_vld ? res_dat[RW-1:22] : '0;
    assign out_quotient = res_vld ? res_dat[21:1]    : '0;
    assign out_div0     = res_vld & res_dat[0];
    assign busy         = (cnt_q != '0);
    assign err          = err_q;
endmodule
